fft_peak_detector: RTL
======================

Name: fft_peak_detector

Overview:
- Downstream consumer of the FFT core's Avalon-ST source port; the FFT is fed by the sink-side control block (8192-point frames, sop/eop/valid framing).
- Computes the squared magnitude of each output bin, finds the largest bin in the positive-frequency half of each frame, and reports bin index and magnitude once per frame.
- The result drives note detection for the Guitar Hero game logic.

Parameters:
- DATA_W, 16, width of source_real / source_imag (signed two's complement)
- FFT_PTS, 8192, points per frame
- BIN_W, 13, bin index width (log2 FFT_PTS)
- MIN_BIN, 1, lowest bin searched; bins below it are ignored (excludes DC)
- MAG_THRESH, 32'd4096, minimum squared magnitude for a valid detection

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- source_valid  in  1  FFT output beat valid
- source_sop  in  1  first bin of frame
- source_eop  in  1  last bin of frame
- source_error  in  2  FFT error code; nonzero marks the frame bad
- source_real  in  DATA_W  real part, signed
- source_imag  in  DATA_W  imaginary part, signed
- source_ready  out  1  backpressure to FFT
- peak_valid  out  1  one-cycle pulse: result registers updated
- peak_found  out  1  peak_mag >= MAG_THRESH, qualified by peak_valid
- peak_bin  out  BIN_W  index of largest bin
- peak_mag  out  2*DATA_W  squared magnitude of that bin, unsigned
- frame_error  out  1  one-cycle pulse: frame discarded

Behaviour:
- Reset values: source_ready=0, peak_valid=0, peak_found=0, peak_bin=0, peak_mag=0, frame_error=0. FSM goes to IDLE and the pipeline is flushed. From the first cycle after reset deasserts, source_ready=1 permanently; the block never stalls.
- A beat is accepted when source_valid=1. Gaps with valid=0 are allowed mid-frame and do not advance the bin counter.
- FSM states:
  - IDLE: beats without sop are ignored. A beat with sop sets bin=0, starts the frame, and goes to FRAME.
  - FRAME: each accepted beat increments bin.
  - End of frame: return to IDLE.
- Magnitude pipeline:
  - Stage 1: registers re*re and im*im (each 2*DATA_W-1 bits, signed to unsigned), plus bin index and sop/eop/last flags.
  - Stage 2: sums them. The result is 2*DATA_W bits with no overflow; the max is 2^31 for -32768 in both parts.
  - Stage 3: compare and update.
- Search window: only bins MIN_BIN..FFT_PTS/2-1 are considered. Comparison is strict greater-than, so ties keep the lower bin. Running max is cleared to 0 / bin MIN_BIN at sop.
- Result timing: peak_valid pulses exactly 3 cycles after the eop beat is accepted, with peak_bin/peak_mag/peak_found updated in the same cycle. Results hold until the next peak_valid or reset.
- Good frame: sop on bin 0, eop on bin FFT_PTS-1, source_error==0 on every beat.
- Boundary conditions:
  - sop while in FRAME: current frame aborted and frame_error pulses (at the latency of that beat). The new frame restarts at bin 0 with this beat.
  - eop on a bin != FFT_PTS-1: frame_error pulses, no peak_valid, go to IDLE.
  - bin FFT_PTS-1 accepted without eop: frame_error pulses, go to IDLE.
  - Nonzero source_error on any beat: frame flagged. At eop, frame_error pulses instead of peak_valid.
  - sop and eop on the same beat: treated as eop on bin 0, which is an error.
  - peak_valid and frame_error are never high in the same cycle.
  - Reset mid-frame: partial frame discarded with no pulse on any output. Previous peak_* outputs are cleared to 0.
- Bin counter is BIN_W bits. Wrap at FFT_PTS-1 only occurs via the error path above.

Test Plan:
- Good frame, all bins 0 except bin 100 = (1000, -500): peak_valid 3 cycles after eop, peak_bin=100, peak_mag=1250000, peak_found=1, frame_error never high.
- Bins 200 and 300 both (300,400), mag 250000; bin 0 = (32767,0); bin 5000 = (30000,0): peak_bin=200, peak_mag=250000. DC and upper-half bins are ignored.
- Full frame with random valid=0 gaps, peak at bin 4095 = (-32768,-32768): peak_mag=2147483648, peak_bin=4095.
- Frame with max bin (10,10), mag 200 < 4096: peak_valid=1, peak_found=0, peak_bin correct.
- Error paths, each checked for one frame_error pulse and no peak_valid:
  - eop at bin 4000
  - second sop at bin 3000, then a good 8192-beat frame follows; the following frame yields a correct peak_valid
  - source_error=2'b01 on bin 10
- Reset asserted at bin 6000 for 2 cycles, then a fresh good frame: no pulses during or after the aborted frame. peak_* read 0 until the new frame's peak_valid, which reports that frame's correct values.

Source files
------------

// File: rtl/fft_peak_detector.sv
// Peak-bin finder for the FFT Avalon-ST source stream.
// Squares each bin, tracks the largest positive-frequency bin per frame and
// reports it (or a frame error) three cycles after the frame's last beat.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   source_valid/sop/eop       Avalon-ST framing from the FFT
//   source_error               nonzero marks the current frame bad
//   source_real/source_imag    signed bin value
//   source_ready               always 1 once out of reset
//   peak_valid                 one-cycle pulse, peak_* updated
//   peak_found                 peak_mag >= MAG_THRESH
//   peak_bin/peak_mag          index and squared magnitude of the peak
//   frame_error                one-cycle pulse, frame discarded
module fft_peak_detector #(
    parameter int DATA_W  = 16,
    parameter int FFT_PTS = 8192,
    parameter int BIN_W   = 13,
    parameter int MIN_BIN = 1,
    parameter logic [2*DATA_W-1:0] MAG_THRESH = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  source_valid,
    input  logic                  source_sop,
    input  logic                  source_eop,
    input  logic [1:0]            source_error,
    input  logic [DATA_W-1:0]     source_real,
    input  logic [DATA_W-1:0]     source_imag,
    output logic                  source_ready,
    output logic                  peak_valid,
    output logic                  peak_found,
    output logic [BIN_W-1:0]      peak_bin,
    output logic [2*DATA_W-1:0]   peak_mag,
    output logic                  frame_error
);

    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_PTS - 1);
    localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(FFT_PTS / 2);
    localparam logic [BIN_W-1:0] LOW_BIN  = BIN_W'(MIN_BIN);

    state_t             state;
    logic [BIN_W-1:0]   bin;
    logic               err_seen;

    logic               accept;
    logic               restart;
    logic               beat_live;
    logic [BIN_W-1:0]   beat_bin;
    logic               beat_err;
    logic               is_last;
    logic               end_good;
    logic               end_bad;
    logic               stop;

    logic signed [2*DATA_W-1:0] re_sq;
    logic signed [2*DATA_W-1:0] im_sq;

    // Stage 1: products and per-beat frame flags
    logic               s1_live, s1_start, s1_win, s1_good, s1_bad;
    logic [BIN_W-1:0]   s1_bin;
    logic [2*DATA_W-1:0] s1_re2, s1_im2;

    // Stage 2: magnitude
    logic               s2_live, s2_start, s2_win, s2_good, s2_bad;
    logic [BIN_W-1:0]   s2_bin;
    logic [2*DATA_W-1:0] s2_mag;

    // Stage 3: running maximum
    logic [2*DATA_W-1:0] max_mag;
    logic [BIN_W-1:0]   max_bin;
    logic [2*DATA_W-1:0] base_mag, new_mag;
    logic [BIN_W-1:0]   base_bin, new_bin;
    logic               take;

    assign accept    = source_valid & source_ready;
    assign restart   = accept & source_sop;
    assign beat_live = restart | (accept & (state == FRAME));
    // A sop beat always restarts at bin 0, even mid-frame.
    assign beat_bin  = restart ? '0 : bin;
    assign beat_err  = (source_error != 2'b00) | (err_seen & ~restart);
    assign is_last   = (beat_bin == LAST_BIN);
    assign end_good  = beat_live & source_eop & is_last & ~beat_err;
    // Abort by a new sop, eop on a wrong bin or flagged frame, or the last
    // bin arriving without eop. At most one pulse per beat.
    assign end_bad   = beat_live &
                       ((restart & (state == FRAME)) |
                        (source_eop & ~end_good) |
                        (~source_eop & is_last));
    assign stop      = source_eop | is_last;

    // Squares of signed values are non-negative, so the top bit is always 0.
    assign re_sq = $signed(source_real) * $signed(source_real);
    assign im_sq = $signed(source_imag) * $signed(source_imag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            err_seen <= 1'b0;
            s1_live  <= 1'b0;
            s1_start <= 1'b0;
            s1_win   <= 1'b0;
            s1_good  <= 1'b0;
            s1_bad   <= 1'b0;
            s1_bin   <= '0;
            s1_re2   <= '0;
            s1_im2   <= '0;
        end else begin
            s1_live  <= beat_live;
            s1_start <= restart;
            s1_win   <= (beat_bin >= LOW_BIN) && (beat_bin < HALF_BIN);
            s1_good  <= end_good;
            s1_bad   <= end_bad;
            s1_bin   <= beat_bin;
            s1_re2   <= re_sq;
            s1_im2   <= im_sq;
            if (beat_live) begin
                if (stop) begin
                    state    <= IDLE;
                    err_seen <= 1'b0;
                end else begin
                    state    <= FRAME;
                    bin      <= beat_bin + 1'b1;
                    err_seen <= beat_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_live  <= 1'b0;
            s2_start <= 1'b0;
            s2_win   <= 1'b0;
            s2_good  <= 1'b0;
            s2_bad   <= 1'b0;
            s2_bin   <= '0;
            s2_mag   <= '0;
        end else begin
            s2_live  <= s1_live;
            s2_start <= s1_start;
            s2_win   <= s1_win;
            s2_good  <= s1_good;
            s2_bad   <= s1_bad;
            s2_bin   <= s1_bin;
            s2_mag   <= s1_re2 + s1_im2;
        end
    end

    // The sop beat sees a cleared maximum so a new frame never inherits
    // the previous frame's peak. Strict > keeps the lower bin on ties.
    always_comb begin
        base_mag = s2_start ? '0 : max_mag;
        base_bin = s2_start ? LOW_BIN : max_bin;
        take     = s2_live & s2_win & (s2_mag > base_mag);
        new_mag  = take ? s2_mag : base_mag;
        new_bin  = take ? s2_bin : base_bin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            source_ready <= 1'b0;
            max_mag      <= '0;
            max_bin      <= LOW_BIN;
            peak_valid   <= 1'b0;
            peak_found   <= 1'b0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            frame_error  <= 1'b0;
        end else begin
            source_ready <= 1'b1;
            peak_valid   <= s2_good;
            frame_error  <= s2_bad;
            if (s2_live) begin
                max_mag <= new_mag;
                max_bin <= new_bin;
            end
            if (s2_good) begin
                peak_bin   <= new_bin;
                peak_mag   <= new_mag;
                peak_found <= (new_mag >= MAG_THRESH);
            end
        end
    end

endmodule
